// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//
// Pays out a change amount one coin at a time to the coin hopper. It always
// picks the largest coin that still fits the amount owed and is in stock.
// Each coin is presented on coin_valid/coin and held until the hopper
// acknowledges it with coin_ack. A stock counter is kept per denomination.
// Stock can be topped up one coin at a time while the block is idle.
//
// Coin code (shared with the coin input path):
//   00 = 5, 01 = 10, 10 = 20, 11 = 50   (amounts in units of 100)
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   start          in   1-cycle request, sampled only in IDLE
//   change_amount  in   [15:0] change to return
//   coin_ack       in   hopper has released the presented coin
//   refill_en      in   add one coin of refill_coin to stock (IDLE only)
//   refill_coin    in   [1:0] denomination to refill
//   coin_valid     out  coin presented to hopper
//   coin           out  [1:0] denomination presented
//   busy           out  high in every state except IDLE
//   done           out  1-cycle pulse on successful completion
//   error          out  1-cycle pulse on failure
//   remaining      out  [15:0] change still owed
//   stock_500 .. stock_5000  out  [3:0] current stock per denomination
// ---------------------------------------------------------------------------
module change_dispenser #(
  parameter logic [3:0] INIT_STOCK = 4'd10,
  parameter logic [3:0] STOCK_MAX  = 4'd15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] change_amount,
  input  logic        coin_ack,
  input  logic        refill_en,
  input  logic [1:0]  refill_coin,
  output logic        coin_valid,
  output logic [1:0]  coin,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] remaining,
  output logic [3:0]  stock_500,
  output logic [3:0]  stock_1000,
  output logic [3:0]  stock_2000,
  output logic [3:0]  stock_5000
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] ISSUE  = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] FAIL   = 3'd4;

  localparam logic [1:0] COIN_5  = 2'b00;
  localparam logic [1:0] COIN_10 = 2'b01;
  localparam logic [1:0] COIN_20 = 2'b10;
  localparam logic [1:0] COIN_50 = 2'b11;

  logic [2:0]  state;
  logic [1:0]  coin_q;
  logic [15:0] remaining_q;
  logic [3:0]  stock_q [0:3];

  logic        sel_found;
  logic [1:0]  sel_coin;
  logic        amount_bad;
  logic        ack_taken;
  logic        refill_taken;

  function automatic logic [15:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_5:  coin_value = 16'd5;
      COIN_10: coin_value = 16'd10;
      COIN_20: coin_value = 16'd20;
      default: coin_value = 16'd50;
    endcase
  endfunction

  // Amounts that are not a multiple of the smallest coin can never be paid.
  assign amount_bad = (change_amount % 16'd5) != 16'd0;

  // The hopper ack only matters while a coin is actually on offer, and
  // refills only while nothing is being paid out.
  assign ack_taken    = (state == ISSUE) && coin_ack;
  assign refill_taken = (state == IDLE) && refill_en;

  // Greedy choice: the largest coin that fits the amount owed and is in
  // stock. Because a coin is only chosen when its value fits, remaining
  // cannot underflow, and because stock must be non-zero, neither can stock.
  always_comb begin
    sel_found = 1'b0;
    sel_coin  = COIN_5;
    if (remaining_q >= 16'd50 && stock_q[3] != 4'd0) begin
      sel_found = 1'b1;
      sel_coin  = COIN_50;
    end else if (remaining_q >= 16'd20 && stock_q[2] != 4'd0) begin
      sel_found = 1'b1;
      sel_coin  = COIN_20;
    end else if (remaining_q >= 16'd10 && stock_q[1] != 4'd0) begin
      sel_found = 1'b1;
      sel_coin  = COIN_10;
    end else if (remaining_q >= 16'd5 && stock_q[0] != 4'd0) begin
      sel_found = 1'b1;
      sel_coin  = COIN_5;
    end
  end

  // Control FSM with the amount owed and the latched coin. DONE and FAIL
  // each last one cycle, so done/error are single pulses that can never
  // overlap. On failure remaining keeps the unpaid amount until the next
  // start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      coin_q      <= COIN_5;
      remaining_q <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            remaining_q <= change_amount;
            state       <= amount_bad ? FAIL : SELECT;
          end
        end
        SELECT: begin
          if (remaining_q == 16'd0) begin
            state <= DONE;
          end else if (sel_found) begin
            coin_q <= sel_coin;
            state  <= ISSUE;
          end else begin
            state <= FAIL;
          end
        end
        ISSUE: begin
          // The hopper may stall for any number of cycles; coin stays put.
          if (coin_ack) begin
            remaining_q <= remaining_q - coin_value(coin_q);
            state       <= SELECT;
          end
        end
        DONE:    state <= IDLE;
        FAIL:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stock counters. Refills only happen in IDLE and payouts only in ISSUE,
  // so at most one of the two ever touches a counter in a given cycle.
  // Refills saturate at STOCK_MAX. Coins already paid are never returned,
  // even when the transaction later fails.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        stock_q[i] <= INIT_STOCK;
      end
    end else begin
      if (refill_taken && stock_q[refill_coin] < STOCK_MAX) begin
        stock_q[refill_coin] <= stock_q[refill_coin] + 4'd1;
      end
      if (ack_taken) begin
        stock_q[coin_q] <= stock_q[coin_q] - 4'd1;
      end
    end
  end

  assign coin_valid = (state == ISSUE);
  assign coin       = coin_q;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign error      = (state == FAIL);
  assign remaining  = remaining_q;

  assign stock_500  = stock_q[0];
  assign stock_1000 = stock_q[1];
  assign stock_2000 = stock_q[2];
  assign stock_5000 = stock_q[3];

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
//
// Self-checking bench for change_dispenser. Each payout request is turned
// into an expected coin list, an expected outcome and the expected stock by
// a greedy arithmetic model over a per-denomination stock array. The bench
// then plays hopper with random ack delays. While the block is busy it
// throws ignored start/refill requests at it. Covers reset values, the
// fixed scenarios (85, 0, 7, 600 then 300, ack stall, refill saturation,
// reset mid-payout) and a run of random requests.
// ---------------------------------------------------------------------------
module tb_change_dispenser;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] change_amount;
  logic        coin_ack;
  logic        refill_en;
  logic [1:0]  refill_coin;
  logic        coin_valid;
  logic [1:0]  coin;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] remaining;
  logic [3:0]  stock_500;
  logic [3:0]  stock_1000;
  logic [3:0]  stock_2000;
  logic [3:0]  stock_5000;

  int check_count = 0;
  int pass_count  = 0;

  int model_stock [4];
  int exp_coins [$];
  bit exp_fail;
  int exp_left;
  bit noise_en;

  change_dispenser #(
    .INIT_STOCK(4'd10),
    .STOCK_MAX (4'd15)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .change_amount(change_amount),
    .coin_ack     (coin_ack),
    .refill_en    (refill_en),
    .refill_coin  (refill_coin),
    .coin_valid   (coin_valid),
    .coin         (coin),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .remaining    (remaining),
    .stock_500    (stock_500),
    .stock_1000   (stock_1000),
    .stock_2000   (stock_2000),
    .stock_5000   (stock_5000)
  );

  always #5 clock = ~clock;

  function automatic int coin_value(input int d);
    case (d)
      0:       return 5;
      1:       return 10;
      2:       return 20;
      default: return 50;
    endcase
  endfunction

  function automatic logic [3:0] observed_stock(input int d);
    case (d)
      0:       return stock_500;
      1:       return stock_1000;
      2:       return stock_2000;
      default: return stock_5000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  // One busy cycle, optionally with start/refill requests that must be ignored.
  task automatic applyStimulus();
    if (noise_en) begin
      start         = 1'($urandom_range(0, 1));
      refill_en     = 1'($urandom_range(0, 1));
      refill_coin   = 2'($urandom_range(0, 3));
      change_amount = 16'($urandom_range(0, 300));
    end
    stepCycle();
    start     = 1'b0;
    refill_en = 1'b0;
  endtask

  task automatic checkStock(input string tag);
    for (int d = 0; d < 4; d++)
      checkOutput($sformatf("%s stock[%0d]", tag, d), 32'(observed_stock(d)),
                  32'(model_stock[d]));
  endtask

  task automatic resetDut();
    reset     = 1'b1;
    start     = 1'b0;
    coin_ack  = 1'b0;
    refill_en = 1'b0;
    stepCycle();
    reset = 1'b0;
    for (int d = 0; d < 4; d++) model_stock[d] = 10;
  endtask

  // Greedy payout computed directly on the stock array.
  task automatic buildModel(input int amount);
    bit found;
    exp_coins.delete();
    exp_fail = 1'b0;
    exp_left = amount;
    if (amount % 5 != 0) begin
      exp_fail = 1'b1;
      return;
    end
    while (exp_left > 0) begin
      found = 1'b0;
      for (int d = 3; d >= 0; d--) begin
        if (!found && coin_value(d) <= exp_left && model_stock[d] > 0) begin
          found = 1'b1;
          exp_coins.push_back(d);
          model_stock[d]--;
          exp_left -= coin_value(d);
        end
      end
      if (!found) begin
        exp_fail = 1'b1;
        break;
      end
    end
  endtask

  task automatic refillCoin(input int d);
    refill_coin = 2'(d);
    refill_en   = 1'b1;
    stepCycle();
    refill_en = 1'b0;
    if (model_stock[d] < 15) model_stock[d]++;
    checkOutput($sformatf("refill stock[%0d]", d), 32'(observed_stock(d)),
                32'(model_stock[d]));
  endtask

  // One complete request; rc >= 0 adds a refill in the same cycle as start.
  task automatic runChange(input int amount, input int dmin, input int dmax,
                           input int rc);
    int steps, idx, exp_steps, rem_now, d;
    logic [1:0] held_coin;
    bit finished, busy_ok, hold_ok;
    if (rc >= 0 && model_stock[rc] < 15) model_stock[rc]++;
    buildModel(amount);
    rem_now   = amount;
    idx       = 0;
    exp_steps = (amount % 5 != 0) ? 1 : 2;
    busy_ok   = 1'b1;
    hold_ok   = 1'b1;
    finished  = 1'b0;
    change_amount = 16'(amount);
    start         = 1'b1;
    if (rc >= 0) begin
      refill_en   = 1'b1;
      refill_coin = 2'(rc);
    end
    stepCycle();
    start     = 1'b0;
    refill_en = 1'b0;
    steps     = 1;
    while (!finished && steps < 2000) begin
      if (coin_valid === 1'b1) begin
        if (idx < exp_coins.size())
          checkOutput($sformatf("amt %0d coin %0d", amount, idx), 32'(coin),
                      32'(exp_coins[idx]));
        else
          checkOutput($sformatf("amt %0d extra coin", amount), 32'd1, 32'd0);
        checkOutput("remaining before ack", 32'(remaining), 32'(rem_now));
        held_coin = coin;
        d = $urandom_range(dmax, dmin);
        repeat (d) begin
          applyStimulus();
          steps++;
          if (!(coin_valid === 1'b1 && coin === held_coin &&
                remaining === 16'(rem_now)))
            hold_ok = 1'b0;
        end
        coin_ack = 1'b1;
        stepCycle();
        coin_ack = 1'b0;
        steps++;
        if (idx < exp_coins.size()) rem_now -= coin_value(exp_coins[idx]);
        checkOutput("valid drops after ack", 32'(coin_valid), 32'd0);
        checkOutput("remaining after ack", 32'(remaining), 32'(rem_now));
        exp_steps += d + 2;
        idx++;
      end else if (done === 1'b1 || error === 1'b1) begin
        finished = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        applyStimulus();
        steps++;
      end
    end
    if (!finished) begin
      checkOutput($sformatf("amt %0d timeout", amount), 32'd0, 32'd1);
    end else begin
      checkOutput($sformatf("amt %0d done", amount), 32'(done), 32'(!exp_fail));
      checkOutput($sformatf("amt %0d error", amount), 32'(error), 32'(exp_fail));
      checkOutput($sformatf("amt %0d latency", amount), 32'(steps), 32'(exp_steps));
      checkOutput($sformatf("amt %0d coins paid", amount), 32'(idx),
                  32'(exp_coins.size()));
      checkOutput($sformatf("amt %0d remaining", amount), 32'(remaining),
                  32'(exp_left));
      checkOutput("busy at end pulse", 32'(busy), 32'd1);
      checkOutput("busy while working", 32'(busy_ok), 32'd1);
      checkOutput("coin held during stall", 32'(hold_ok), 32'd1);
      stepCycle();
      checkOutput("back to idle", 32'({busy, done, error, coin_valid}), 32'd0);
      checkOutput("remaining held", 32'(remaining), 32'(exp_left));
      checkStock($sformatf("amt %0d", amount));
    end
  endtask

  // Starts a payout and resets the block while the second coin is on offer.
  task automatic resetDuringIssue();
    int waited;
    int seen;
    change_amount = 16'd85;
    start         = 1'b1;
    stepCycle();
    start  = 1'b0;
    waited = 0;
    seen   = 0;
    while (seen < 2 && waited < 50) begin
      if (coin_valid === 1'b1) begin
        seen++;
        if (seen == 1) begin
          coin_ack = 1'b1;
          stepCycle();
          coin_ack = 1'b0;
        end
      end else begin
        stepCycle();
      end
      waited++;
    end
    checkOutput("reset test reached issue", 32'(seen), 32'd2);
    applyStimulus();
    applyStimulus();
    resetDut();
    checkOutput("mid reset coin_valid", 32'(coin_valid), 32'd0);
    checkOutput("mid reset coin", 32'(coin), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset done/error", 32'({done, error}), 32'd0);
    checkOutput("mid reset remaining", 32'(remaining), 32'd0);
    checkStock("mid reset");
  endtask

  initial begin
    int amt;
    reset         = 1'b1;
    start         = 1'b0;
    change_amount = 16'd0;
    coin_ack      = 1'b0;
    refill_en     = 1'b0;
    refill_coin   = 2'b00;
    noise_en      = 1'b1;
    stepCycle();
    resetDut();
    checkOutput("reset coin_valid", 32'(coin_valid), 32'd0);
    checkOutput("reset coin", 32'(coin), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset error", 32'(error), 32'd0);
    checkOutput("reset remaining", 32'(remaining), 32'd0);
    checkStock("reset");

    runChange(85, 0, 1, -1);
    checkOutput("85 stock_5000 is 9", 32'(stock_5000), 32'd9);

    resetDut();
    runChange(0, 0, 0, -1);
    runChange(7, 0, 0, -1);
    runChange(600, 0, 3, -1);
    checkOutput("600 stock_5000", 32'(stock_5000), 32'd0);
    checkOutput("600 stock_2000", 32'(stock_2000), 32'd5);
    runChange(300, 0, 2, -1);
    checkOutput("300 leaves 50 owed", 32'(remaining), 32'd50);

    resetDut();
    for (int i = 0; i < 6; i++) refillCoin(3);
    runChange(70, 5, 5, -1);
    runChange(55, 0, 2, 2);

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 2) == 0)
        for (int k = 0; k < 3; k++) refillCoin($urandom_range(0, 3));
      amt = $urandom_range(0, 40) * 5;
      if ($urandom_range(0, 5) == 0) amt += $urandom_range(1, 4);
      runChange(amt, 0, 3, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : -1);
    end

    resetDuringIssue();

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
